// File: rtl/mmio_uart_tx_if.sv
// Core data-memory bus as seen by the memory-mapped UART console.
// master = core side, slave = peripheral side.
interface mmio_uart_tx_if;
  logic [31:0] data;
  logic [31:0] addr;
  logic        mem_read;
  logic        mem;
  logic [31:0] rdata;

  modport master (output data, addr, mem_read, mem, input rdata);
  modport slave  (input data, addr, mem_read, mem, output rdata);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: byte FIFO fed by stores, 8N1 serializer, status word.
// Optional even-parity bit between data and stop when UART_PARITY_EN is defined.
module mmio_uart_tx #(
  parameter int unsigned BASE_ADDR    = 1024,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic         clk,
  input  logic         rst,
  mmio_uart_tx_if.slave bus,
  output logic         tx,
  output logic         busy,
  output logic         overflow
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT + 1);
  localparam logic [31:0]     DATA_ADDR = 32'(BASE_ADDR);
  localparam logic [31:0]     STAT_ADDR = 32'(BASE_ADDR + 4);
  localparam logic [CW-1:0]   LAST_CLK  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count, count_nxt;
  logic [CW-1:0]   clk_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
`ifdef UART_PARITY_EN
  logic            parity;
`endif

  logic store, push_req, push, pop, drop, clr, full, empty, bit_end, idle_nxt;
  logic unused_data;

  assign unused_data = ^bus.data[31:8];

  // Bus decode, FIFO occupancy and next-cycle idle prediction for busy.
  always_comb begin
    store     = bus.mem && !bus.mem_read;
    push_req  = store && (bus.addr == DATA_ADDR);
    clr       = store && (bus.addr == STAT_ADDR) && bus.data[3];
    full      = (count == FULL_CNT);
    empty     = (count == '0);
    pop       = (state == IDLE) && !empty;
    push      = push_req && (!full || pop);
    drop      = push_req && !push;
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNTW'(1);
    else if (pop && !push) count_nxt = count - CNTW'(1);
    bit_end   = (clk_cnt == LAST_CLK);
    idle_nxt  = ((state == IDLE) && empty) || ((state == STOP) && bit_end);
  end

  assign bus.rdata = (bus.mem && bus.mem_read && (bus.addr == STAT_ADDR))
                   ? {28'b0, overflow, full, empty, busy} : 32'b0;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.data[7:0];
  end

  // FIFO pointers and status flags; a dropped store outranks a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      if (drop)     overflow <= 1'b1;
      else if (clr) overflow <= 1'b0;
      busy <= !idle_nxt || (count_nxt != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
`ifdef UART_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (!empty) begin
            shift <= fifo_mem[rd_ptr];
`ifdef UART_PARITY_EN
            parity <= ^fifo_mem[rd_ptr];
`endif
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
              tx    <= parity;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              // Next bit is shift[1] because the register shifts on this same edge.
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            clk_cnt <= '0;
            tx      <= 1'b1;
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: expected line waveform is built from frame rules.
module tb_mmio_uart_tx;
  localparam int unsigned C     = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned BASE  = 1024;
`ifdef UART_PARITY_EN
  localparam int unsigned FL = 11 * C;
`else
  localparam int unsigned FL = 10 * C;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx, busy, overflow;
  mmio_uart_tx_if bus();

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .tx(tx), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // Line level at cycle t of a frame carrying byte b.
  function automatic logic frame_bit(logic [7:0] b, int unsigned t);
    int unsigned i;
    i = t / C;
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] status_word(logic o, logic f, logic e, logic b);
    return {28'b0, o, f, e, b};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.mem = 1'b0; bus.mem_read = 1'b0; bus.addr = '0; bus.data = '0;
  endtask

  task automatic store_cycle(logic [31:0] a, logic [31:0] d);
    bus.mem = 1'b1; bus.mem_read = 1'b0; bus.addr = a; bus.data = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic load_check(string tag, logic [31:0] a, logic [31:0] exp);
    bus.mem = 1'b1; bus.mem_read = 1'b1; bus.addr = a; bus.data = $urandom();
    #1 chk(tag, bus.rdata, exp);
    bus_idle();
  endtask

  task automatic check_frame(logic [7:0] b, int unsigned from);
    for (int unsigned t = from; t < FL; t++) begin
      @(negedge clk);
      chk($sformatf("tx byte=%02h t=%0d", b, t), 32'(tx), 32'(frame_bit(b, t)));
    end
  endtask

  initial begin
    logic [7:0]  bytes[$];
    logic [31:0] d;
    int unsigned n_acc, occ;
    logic        dropped;

    bus_idle();
    repeat (2) @(negedge clk);
    chk("reset tx", 32'(tx), 32'(1'b1));
    chk("reset busy", 32'(busy), 32'(1'b0));
    chk("reset overflow", 32'(overflow), 32'(1'b0));
    load_check("reset status", BASE + 4, status_word(1'b0, 1'b0, 1'b1, 1'b0));
    rst = 1'b0;
    @(negedge clk);

    // Isolated frames: directed bytes then random ones, with random idle gaps.
    bytes = '{8'h41, 8'h07};
    repeat (4) bytes.push_back(8'($urandom()));
    foreach (bytes[k]) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("idle tx", 32'(tx), 32'(1'b1));
      end
      d = $urandom();
      d[7:0] = bytes[k];
      store_cycle(BASE, d);
      chk("latency tx", 32'(tx), 32'(1'b1));
      chk("busy after push", 32'(busy), 32'(1'b1));
      check_frame(bytes[k], 0);
      @(negedge clk);
      chk("post frame tx", 32'(tx), 32'(1'b1));
      chk("post frame busy", 32'(busy), 32'(1'b0));
      chk("post frame overflow", 32'(overflow), 32'(1'b0));
    end

    // Back-to-back stores overrun the FIFO; the first frame starts one edge after the first push.
    exp_q.delete();
    n_acc = 0;
    dropped = 1'b0;
    for (int unsigned k = 0; k < 10; k++) begin
      occ = n_acc - ((k > 1) ? 1 : 0);
      if (occ < DEPTH || k == 1) begin
        exp_q.push_back(8'(k));
        n_acc++;
      end else begin
        dropped = 1'b1;
      end
      store_cycle(BASE, 32'(k));
      if (k >= 1) chk($sformatf("b2b first tx t=%0d", k - 1), 32'(tx), 32'(frame_bit(exp_q[0], k - 1)));
    end
    chk("b2b accepted", 32'(exp_q.size()), 32'(9));
    chk("b2b overflow", 32'(overflow), 32'(dropped));
    load_check("b2b status", BASE + 4,
               status_word(dropped, (n_acc - 1) == DEPTH, 1'b0, 1'b1));
    check_frame(exp_q[0], 9);
    for (int i = 1; i < exp_q.size(); i++) begin
      @(negedge clk);
      chk("b2b gap tx", 32'(tx), 32'(1'b1));
      chk("b2b gap busy", 32'(busy), 32'(1'b1));
      check_frame(exp_q[i], 0);
    end
    @(negedge clk);
    chk("b2b drained busy", 32'(busy), 32'(1'b0));
    load_check("b2b drained status", BASE + 4, status_word(1'b1, 1'b0, 1'b1, 1'b0));

    // Overflow clear needs data[3]=1 at the status address.
    store_cycle(BASE + 4, 32'hFFFF_FFF7);
    chk("clear bit3=0 keeps overflow", 32'(overflow), 32'(1'b1));
    store_cycle(BASE + 4, 32'h0000_0008);
    chk("clear bit3=1", 32'(overflow), 32'(1'b0));

    // Decode: non-matching stores and loads must be ignored.
    store_cycle(BASE + 4, 32'h0000_0041);
    store_cycle(BASE + 1, 32'h0000_0041);
    load_check("load data addr", BASE, 32'h0);
    bus.mem = 1'b0; bus.mem_read = 1'b1; bus.addr = BASE + 4;
    #1 chk("load without mem", bus.rdata, 32'h0);
    bus_idle();
    bus.mem = 1'b1; bus.mem_read = 1'b1; bus.addr = BASE;
    @(negedge clk);
    bus_idle();
    repeat (12) begin
      @(negedge clk);
      chk("decode tx idle", 32'(tx), 32'(1'b1));
    end
    chk("decode busy", 32'(busy), 32'(1'b0));
    load_check("decode status", BASE + 4, status_word(1'b0, 1'b0, 1'b1, 1'b0));

    // Reset during data bit 3 of 0x55 with three more bytes queued.
    store_cycle(BASE, 32'h55);
    chk("rst-test latency tx", 32'(tx), 32'(1'b1));
    for (int unsigned t = 0; t < 3; t++) begin
      store_cycle(BASE, 32'($urandom()));
      chk($sformatf("rst-test tx t=%0d", t), 32'(tx), 32'(frame_bit(8'h55, t)));
    end
    for (int unsigned t = 3; t <= 4 * C + 1; t++) begin
      @(negedge clk);
      chk($sformatf("rst-test tx t=%0d", t), 32'(tx), 32'(frame_bit(8'h55, t)));
    end
    chk("rst-test in bit3 busy", 32'(busy), 32'(1'b1));
    #1 rst = 1'b1;
    #1;
    chk("mid-frame reset tx", 32'(tx), 32'(1'b1));
    chk("mid-frame reset busy", 32'(busy), 32'(1'b0));
    load_check("mid-frame reset status", BASE + 4, status_word(1'b0, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * FL) begin
      @(negedge clk);
      chk("post reset tx idle", 32'(tx), 32'(1'b1));
    end
    chk("post reset busy", 32'(busy), 32'(1'b0));
    load_check("post reset status", BASE + 4, status_word(1'b0, 1'b0, 1'b1, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
